dmem_responder: RTL and testbench

Data-memory target for the RISC-V pipeline's MEM stage. It accepts one load or store request at a time over a valid/ready handshake and performs the access after a fixed, parameterised latency. It returns the read data (byte-lane extracted and sign- or zero-extended) or a write acknowledgement over a valid/ready response channel. It is the memory end of the MEM-stage access path and replaces the single-cycle data memory when multi-cycle memory timing is modelled.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 75 +++++++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder: access-size
//               encodings and the responder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering for the data memory.
//               Store side: 4-bit lane mask and lane-replicated write data.
//               Load side : lane extraction plus sign/zero extension.
//               Also flags accesses that must be rejected (fault).
// Ports       : size, addrLo, isUnsigned, wdata, rword (in)
//               wmask, wdataRep, rdata, fault (out)
// Config      : DMEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               accesses raise fault; otherwise low address bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic        isUnsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdataRep,
    output logic [31:0] rdata,
    output logic        fault
);

    logic [7:0]  w_rByte;
    logic [15:0] w_rHalf;
    logic        w_misaligned;

    assign w_rByte = rword[{addrLo, 3'b000} +: 8];
    assign w_rHalf = addrLo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        wmask        = 4'b0000;
        wdataRep     = '0;
        rdata        = '0;
        w_misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                wmask    = 4'b0001 << addrLo;
                wdataRep = {4{wdata[7:0]}};
                rdata    = isUnsigned ? {24'd0, w_rByte} : {{24{w_rByte[7]}}, w_rByte};
            end
            SIZE_H: begin
                wmask        = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataRep     = {2{wdata[15:0]}};
                rdata        = isUnsigned ? {16'd0, w_rHalf} : {{16{w_rHalf[15]}}, w_rHalf};
                w_misaligned = addrLo[0];
            end
            SIZE_W: begin
                wmask        = 4'b1111;
                wdataRep     = wdata;
                rdata        = rword;
                w_misaligned = |addrLo;
            end
            default: begin
                // reserved size: nothing written, nothing read
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault = (size == SIZE_RSV) | w_misaligned;
`else
    // Misalignment is tolerated: the low address bits are simply dropped
    // by the half/word lane selection above.
    logic w_unusedMisaligned;
    assign w_unusedMisaligned = w_misaligned;
    assign fault = (size == SIZE_RSV);
`endif

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data-memory target for the MEM stage. Accepts one
//               load/store at a time (valid/ready), performs it after LATENCY
//               cycles and returns read data / write ack with an error flag.
// Ports       : clk, rst (sync, active-high)
//               req_valid/req_ready, req_we, req_size, req_unsigned,
//               req_addr, req_wdata           - request channel
//               resp_valid/resp_ready, resp_rdata, resp_err - response channel
// Config      : DMEM_MISALIGN_TRAP_EN (see dmem_lane_align)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_ADDR_W   = $clog2(DEPTH_WORDS);
    localparam int c_CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int c_CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_respValid;
    logic [31:0]          r_respRdata;
    logic                 r_respErr;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_accept;
    logic                 w_enterResp;
    logic                 w_aWe;
    logic [1:0]           w_aSize;
    logic                 w_aUnsigned;
    logic [31:0]          w_aAddr;
    logic [31:0]          w_aWdata;
    logic [c_ADDR_W-1:0]  w_idx;
    logic [3:0]           w_wmask;
    logic [31:0]          w_wdataRep;
    logic [31:0]          w_rdata;
    logic                 w_fault;
    logic                 w_unusedAddrHi;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;

    // The memory access happens on the edge that enters RESP. With a
    // single-cycle latency that is the accept edge itself, so the access
    // must use the live request instead of the captured copy.
    generate
        if (LATENCY == 1) begin : g_directAccess
            assign w_aWe       = req_we;
            assign w_aSize     = req_size;
            assign w_aUnsigned = req_unsigned;
            assign w_aAddr     = req_addr;
            assign w_aWdata    = req_wdata;
            assign w_enterResp = (r_state == ST_IDLE) && w_accept;
        end else begin : g_capturedAccess
            assign w_aWe       = r_we;
            assign w_aSize     = r_size;
            assign w_aUnsigned = r_unsigned;
            assign w_aAddr     = r_addr;
            assign w_aWdata    = r_wdata;
            assign w_enterResp = (r_state == ST_WAIT) && (r_cnt == '0);
        end
    endgenerate

    // Upper address bits alias; addresses wrap modulo DEPTH_WORDS*4.
    assign w_idx          = w_aAddr[c_ADDR_W+1:2];
    assign w_unusedAddrHi = ^w_aAddr[31:c_ADDR_W+2];

    dmem_lane_align u_laneAlign (
        .size       (w_aSize),
        .addrLo     (w_aAddr[1:0]),
        .isUnsigned (w_aUnsigned),
        .wdata      (w_aWdata),
        .rword      (r_mem[w_idx]),
        .wmask      (w_wmask),
        .wdataRep   (w_wdataRep),
        .rdata      (w_rdata),
        .fault      (w_fault)
    );

    // Storage is never reset. A reset arriving while in WAIT blocks the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_enterResp && w_aWe && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdataRep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= SIZE_B;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_respValid <= 1'b0;
            r_respRdata <= '0;
            r_respErr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_cnt      <= c_CNT_W'(c_CNT_INIT);
                        r_state    <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_respValid && resp_ready) begin
                        r_state     <= ST_IDLE;
                        r_respValid <= 1'b0;
                        r_respRdata <= '0;
                        r_respErr   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Response is latched together with the memory access and held
            // unchanged until the consumer takes it.
            if (w_enterResp) begin
                r_respValid <= 1'b1;
                r_respErr   <= w_fault;
                r_respRdata <= (w_fault || w_aWe) ? 32'd0 : w_rdata;
            end
        end
    end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking directed bench for dmem_responder. Expected
//               responses are queued at request accept and compared when the
//               response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int c_DEPTH = 64;
    localparam int c_LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    dmem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .LATENCY     (c_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRd, input logic expErr,
                         input bit push, input string tag);
        exp_t e;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        if (push) begin
            e.rdata = expRd;
            e.err   = expErr;
            e.tag   = tag;
            sbq.push_back(e);
        end
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, check latency and contents against the queue.
    // With hold > 0 the consumer stalls while a stray store is presented.
    task automatic collect(input int hold);
        int   n;
        exp_t e;
        string tag;
        n = 0;
        resp_ready = (hold == 0);
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() == 0) begin
            tag = "noexp";
            e.rdata = 32'hx; e.err = 1'bx;
        end else begin
            e = sbq.pop_front();
            tag = e.tag;
        end
        // Valid first seen after edge T+LAT-1, so it is sampled high at edge T+LAT.
        check({tag, "_latency"}, n + 1, c_LAT);
        check({tag, "_rdata"}, resp_rdata, e.rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        if (hold > 0) begin
            req_valid    = 1'b1;
            req_we       = 1'b1;
            req_size     = SIZE_W;
            req_unsigned = 1'b0;
            req_addr     = 32'h40;
            req_wdata    = 32'h1111_1111;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
                check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
                check({tag, "_hold_err"}, {31'd0, resp_err}, {31'd0, e.err});
                check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "_released"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SIZE_W;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Word round-trip
        issue(1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, "st_w10");
        collect(0);
        issue(1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, "ld_w10");
        collect(0);

        // Byte store and extension
        issue(1'b1, SIZE_B, 1'b0, 32'h13, 32'h0000_0080, 32'd0, 1'b0, 1'b1, "st_b13");
        collect(0);
        issue(1'b0, SIZE_B, 1'b0, 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b1, "ld_bs13");
        collect(0);
        issue(1'b0, SIZE_B, 1'b1, 32'h13, 32'd0, 32'h0000_0080, 1'b0, 1'b1, "ld_bu13");
        collect(0);
        issue(1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, 32'h80AD_BEEF, 1'b0, 1'b1, "ld_w10b");
        collect(0);
        issue(1'b0, SIZE_H, 1'b0, 32'h12, 32'd0, 32'hFFFF_80AD, 1'b0, 1'b1, "ld_hs12");
        collect(0);
        issue(1'b0, SIZE_H, 1'b1, 32'h10, 32'd0, 32'h0000_BEEF, 1'b0, 1'b1, "ld_hu10");
        collect(0);

        // Address wrap: upper bits ignored
        issue(1'b0, SIZE_W, 1'b0, 32'h10 + c_DEPTH * 4, 32'd0, 32'h80AD_BEEF, 1'b0, 1'b1, "ld_wrap");
        collect(0);

        // Backpressure with a stray request that must not execute
        issue(1'b1, SIZE_W, 1'b0, 32'h40, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1, "st_w40");
        collect(0);
        issue(1'b0, SIZE_W, 1'b0, 32'h10, 32'd0, 32'h80AD_BEEF, 1'b0, 1'b1, "ld_bp");
        collect(5);
        issue(1'b0, SIZE_W, 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b1, "ld_w40");
        collect(0);

        // Misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(1'b0, SIZE_W, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 1'b1, "ld_mis12");
`else
        issue(1'b0, SIZE_W, 1'b0, 32'h12, 32'd0, 32'h80AD_BEEF, 1'b0, 1'b1, "ld_mis12");
`endif
        collect(0);

        // Reset while in WAIT: store dropped, no response
        issue(1'b1, SIZE_W, 1'b0, 32'h20, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b1, "st_w20");
        collect(0);
        issue(1'b1, SIZE_W, 1'b0, 32'h20, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "st_w20_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        check("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, SIZE_W, 1'b0, 32'h20, 32'd0, 32'hA5A5_A5A5, 1'b0, 1'b1, "ld_w20");
        collect(0);

        // Reserved size
        issue(1'b1, SIZE_W, 1'b0, 32'h30, 32'h0102_0304, 32'd0, 1'b0, 1'b1, "st_w30");
        collect(0);
        issue(1'b1, SIZE_RSV, 1'b0, 32'h30, 32'h5555_5555, 32'd0, 1'b1, 1'b1, "st_rsv30");
        collect(0);
        issue(1'b0, SIZE_W, 1'b0, 32'h30, 32'd0, 32'h0102_0304, 1'b0, 1'b1, "ld_w30");
        collect(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_responder
`default_nettype wire
